// File: rtl/mic_sample_fifo.sv
// rtl/mic_sample_fifo.sv - single-clock mic sample FIFO with level thresholds,
// sticky error flags, synchronous flush and selectable FWFT read.
module mic_sample_fifo #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 7,
  parameter int AF_THRESH = 120,
  parameter int AE_THRESH = 8,
  parameter bit FWFT      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              rd_acc, wr_acc, rd_go, wr_go;

  assign full         = (level == DEPTH_L);
  assign empty        = (level == '0);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);
  assign rd_go  = rd_acc & ~flush;
  assign wr_go  = wr_acc & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_go) wr_ptr <= wr_ptr + 1'b1;
      if (rd_go) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_go, rd_go})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Set beats clear; a flush cycle never raises an error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en & ~wr_acc & ~flush) | (overflow & ~clr_err);
      underflow <= (rd_en & ~rd_acc & ~flush) | (underflow & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem[wr_ptr] <= din;
  end

  generate
    if (FWFT) begin : g_fwft
      assign dout       = empty ? '0 : mem[rd_ptr];
      assign dout_valid = ~empty;
    end else begin : g_reg
      // Reads old contents when the write targets the slot being read.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout       <= '0;
          dout_valid <= 1'b0;
        end else begin
          dout_valid <= rd_go;
          if (rd_go) dout <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule
